// File: rtl/rx_port_completion_demux.sv
// rx_port_completion_demux: return path of the rx_port read-request mux.
// Keeps a per-source count of outstanding DWs (main, SG RX, SG TX), routes
// tagged completion data to its consumer through one register stage, and
// flags completion (DONE) and protocol errors (ERR, sticky until RST).
module rx_port_completion_demux #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_EN_WIDTH   = $clog2(C_DATA_WIDTH/32) + 1,
  parameter int C_OUT_WIDTH  = 14
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_ISSUED,
  input  logic [1:0]              REQ_TAG,
  input  logic [9:0]              REQ_LEN,
  input  logic [C_DATA_WIDTH-1:0] CPL_DATA,
  input  logic [C_EN_WIDTH-1:0]   CPL_DATA_EN,
  input  logic [1:0]              CPL_TAG,
  output logic [C_DATA_WIDTH-1:0] RD_DATA,
  output logic [C_EN_WIDTH-1:0]   MAIN_DATA_EN,
  output logic [C_EN_WIDTH-1:0]   SG_RX_DATA_EN,
  output logic [C_EN_WIDTH-1:0]   SG_TX_DATA_EN,
  output logic [C_OUT_WIDTH-1:0]  MAIN_OUTSTANDING,
  output logic [C_OUT_WIDTH-1:0]  SG_RX_OUTSTANDING,
  output logic [C_OUT_WIDTH-1:0]  SG_TX_OUTSTANDING,
  output logic                    MAIN_DONE,
  output logic                    SG_RX_DONE,
  output logic                    SG_TX_DONE,
  output logic                    ERR
);

  // One extra bit of headroom so cnt + 1024 never wraps before the saturation compare.
  localparam int CW = C_OUT_WIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX = {1'b0, {C_OUT_WIDTH{1'b1}}};
  localparam logic [1:0] TAG_BAD = 2'b11;

  logic [C_OUT_WIDTH-1:0] cnt_q [3];
  logic [C_OUT_WIDTH-1:0] cnt_d [3];
  logic [2:0]             ovf;
  logic [2:0]             unf;
  logic [2:0]             done_d;
  logic [CW-1:0]          req_len_ext;
  logic                   err_d;

  // Effective request length: a zero length field encodes 1024 DWs.
  always_comb begin
    req_len_ext = (REQ_LEN == 10'd0) ? CW'(1024) : CW'(REQ_LEN);
  end

  // Next outstanding count per source: add the issue, saturate, then retire completions.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      logic [CW-1:0] issue;
      logic [CW-1:0] cpl;
      logic [CW-1:0] sum;
      logic [CW-1:0] sat;
      issue  = (REQ_ISSUED && REQ_TAG == 2'(i)) ? req_len_ext : '0;
      cpl    = (CPL_TAG == 2'(i)) ? CW'(CPL_DATA_EN) : '0;
      sum    = CW'(cnt_q[i]) + issue;
      sat    = sum;
      ovf[i] = 1'b0;
      unf[i] = 1'b0;
      if (sum > CNT_MAX) begin
        sat    = CNT_MAX;
        ovf[i] = 1'b1;
      end
      if (cpl > sat) begin
        cnt_d[i] = '0;
        unf[i]   = 1'b1;
      end else begin
        cnt_d[i] = C_OUT_WIDTH'(sat - cpl);
      end
      done_d[i] = (cnt_q[i] != '0) && (cnt_d[i] == '0);
    end
  end

  // Any saturation, underflow or use of the illegal tag latches the error flag.
  always_comb begin
    err_d = ERR | (|ovf) | (|unf)
          | (REQ_ISSUED && REQ_TAG == TAG_BAD)
          | ((CPL_TAG == TAG_BAD) && (CPL_DATA_EN != '0));
  end

  // Register the routed data path, the counters and the status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RD_DATA       <= '0;
      MAIN_DATA_EN  <= '0;
      SG_RX_DATA_EN <= '0;
      SG_TX_DATA_EN <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      MAIN_DONE     <= 1'b0;
      SG_RX_DONE    <= 1'b0;
      SG_TX_DONE    <= 1'b0;
      ERR           <= 1'b0;
    end else begin
      RD_DATA       <= CPL_DATA;
      MAIN_DATA_EN  <= (CPL_TAG == 2'd0) ? CPL_DATA_EN : '0;
      SG_RX_DATA_EN <= (CPL_TAG == 2'd1) ? CPL_DATA_EN : '0;
      SG_TX_DATA_EN <= (CPL_TAG == 2'd2) ? CPL_DATA_EN : '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      MAIN_DONE     <= done_d[0];
      SG_RX_DONE    <= done_d[1];
      SG_TX_DONE    <= done_d[2];
      ERR           <= err_d;
    end
  end

  assign MAIN_OUTSTANDING  = cnt_q[0];
  assign SG_RX_OUTSTANDING = cnt_q[1];
  assign SG_TX_OUTSTANDING = cnt_q[2];

endmodule

// File: tb/tb_rx_port_completion_demux.sv
// Bench for rx_port_completion_demux: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an
// integer model of the outstanding-DW bookkeeping.
module tb_rx_port_completion_demux;

  localparam int DW  = 64;
  localparam int EW  = $clog2(DW/32) + 1;
  localparam int OW  = 14;
  localparam int MAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          REQ_ISSUED = 1'b0;
  logic [1:0]    REQ_TAG = 2'd0;
  logic [9:0]    REQ_LEN = 10'd0;
  logic [DW-1:0] CPL_DATA = '0;
  logic [EW-1:0] CPL_DATA_EN = '0;
  logic [1:0]    CPL_TAG = 2'd0;
  logic [DW-1:0] RD_DATA;
  logic [EW-1:0] MAIN_DATA_EN, SG_RX_DATA_EN, SG_TX_DATA_EN;
  logic [OW-1:0] MAIN_OUTSTANDING, SG_RX_OUTSTANDING, SG_TX_OUTSTANDING;
  logic          MAIN_DONE, SG_RX_DONE, SG_TX_DONE, ERR;

  int n_cmp = 0;
  int n_bad = 0;

  rx_port_completion_demux #(.C_DATA_WIDTH(DW), .C_EN_WIDTH(EW), .C_OUT_WIDTH(OW)) dut (
    .CLK(clk), .RST(RST),
    .REQ_ISSUED(REQ_ISSUED), .REQ_TAG(REQ_TAG), .REQ_LEN(REQ_LEN),
    .CPL_DATA(CPL_DATA), .CPL_DATA_EN(CPL_DATA_EN), .CPL_TAG(CPL_TAG),
    .RD_DATA(RD_DATA),
    .MAIN_DATA_EN(MAIN_DATA_EN), .SG_RX_DATA_EN(SG_RX_DATA_EN), .SG_TX_DATA_EN(SG_TX_DATA_EN),
    .MAIN_OUTSTANDING(MAIN_OUTSTANDING), .SG_RX_OUTSTANDING(SG_RX_OUTSTANDING),
    .SG_TX_OUTSTANDING(SG_TX_OUTSTANDING),
    .MAIN_DONE(MAIN_DONE), .SG_RX_DONE(SG_RX_DONE), .SG_TX_DONE(SG_TX_DONE),
    .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer bookkeeping of what each source still owes.
  int            m_cnt [3];
  int            m_en  [3];
  bit            m_done[3];
  bit            m_err;
  logic [DW-1:0] m_data;

  initial begin
    for (int s = 0; s < 3; s++) begin m_cnt[s] = 0; m_en[s] = 0; m_done[s] = 0; end
    m_err = 0; m_data = '0;
  end

  always @(posedge clk) begin
    if (RST) begin
      for (int s = 0; s < 3; s++) begin m_cnt[s] = 0; m_en[s] = 0; m_done[s] = 0; end
      m_err = 0; m_data = '0;
    end else begin
      m_data = CPL_DATA;
      if (CPL_TAG == 2'd3 && CPL_DATA_EN != 0) m_err = 1;
      if (REQ_ISSUED && REQ_TAG == 2'd3) m_err = 1;
      for (int s = 0; s < 3; s++) begin
        int add, sub, t, nx;
        add = (REQ_ISSUED && int'(REQ_TAG) == s) ? ((REQ_LEN == 0) ? 1024 : int'(REQ_LEN)) : 0;
        sub = (int'(CPL_TAG) == s) ? int'(CPL_DATA_EN) : 0;
        m_en[s] = sub;
        t = m_cnt[s] + add;
        if (t > MAX) begin t = MAX; m_err = 1; end
        if (sub > t) begin nx = 0; m_err = 1; end
        else nx = t - sub;
        m_done[s] = (m_cnt[s] != 0) && (nx == 0);
        m_cnt[s] = nx;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    chk("rd_data", RD_DATA, m_data);
    chk("main_en", 64'(MAIN_DATA_EN), 64'(m_en[0]));
    chk("sgrx_en", 64'(SG_RX_DATA_EN), 64'(m_en[1]));
    chk("sgtx_en", 64'(SG_TX_DATA_EN), 64'(m_en[2]));
    chk("main_cnt", 64'(MAIN_OUTSTANDING), 64'(m_cnt[0]));
    chk("sgrx_cnt", 64'(SG_RX_OUTSTANDING), 64'(m_cnt[1]));
    chk("sgtx_cnt", 64'(SG_TX_OUTSTANDING), 64'(m_cnt[2]));
    chk("main_done", 64'(MAIN_DONE), 64'(m_done[0]));
    chk("sgrx_done", 64'(SG_RX_DONE), 64'(m_done[1]));
    chk("sgtx_done", 64'(SG_TX_DONE), 64'(m_done[2]));
    chk("err", 64'(ERR), 64'(m_err));
  end

  // Apply one cycle of stimulus, then return to idle 2 time units after the edge.
  task automatic step(bit iss, logic [1:0] rt, logic [9:0] rl, logic [1:0] ct, logic [EW-1:0] en);
    REQ_ISSUED  = iss;
    REQ_TAG     = rt;
    REQ_LEN     = rl;
    CPL_TAG     = ct;
    CPL_DATA_EN = en;
    CPL_DATA    = {$urandom, $urandom};
    @(posedge clk); #2;
    REQ_ISSUED  = 1'b0;
    CPL_DATA_EN = '0;
  endtask

  initial begin
    // Reset
    RST = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_main_cnt", 64'(MAIN_OUTSTANDING), 64'd0);
    chk("rst_rd_data", RD_DATA, 64'd0);
    chk("rst_err", 64'(ERR), 64'd0);
    RST = 1'b0;

    // Main request of 8, four beats of 2
    step(1, 2'd0, 10'd8, 0, 0);
    chk("main_req8", 64'(MAIN_OUTSTANDING), 64'd8);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 2'd0, 2);
      chk("main_beat_en", 64'(MAIN_DATA_EN), 64'd2);
      chk("main_beat_cnt", 64'(MAIN_OUTSTANDING), 64'(6 - 2*k));
      chk("main_beat_done", 64'(MAIN_DONE), 64'(k == 3));
    end
    step(0, 0, 0, 0, 0);
    chk("main_done_once", 64'(MAIN_DONE), 64'd0);

    // SG RX request of 1024 (length field 0), 512 beats of 2
    step(1, 2'd1, 10'd0, 0, 0);
    chk("sgrx_1024", 64'(SG_RX_OUTSTANDING), 64'd1024);
    for (int k = 0; k < 512; k++) step(0, 0, 0, 2'd1, 2);
    chk("sgrx_drained", 64'(SG_RX_OUTSTANDING), 64'd0);
    chk("sgrx_done", 64'(SG_RX_DONE), 64'd1);
    chk("sgrx_err0", 64'(ERR), 64'd0);

    // SG TX: counter 2, then issue 4 and complete 2 in the same cycle
    step(1, 2'd2, 10'd2, 0, 0);
    step(1, 2'd2, 10'd4, 2'd2, 2);
    chk("sgtx_same_cnt", 64'(SG_TX_OUTSTANDING), 64'd4);
    chk("sgtx_same_done", 64'(SG_TX_DONE), 64'd0);
    chk("sgtx_same_en", 64'(SG_TX_DATA_EN), 64'd2);

    // Interleave main and SG TX completions
    step(1, 2'd0, 10'd6, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, (k % 2 == 0) ? 2'd0 : 2'd2, 2);
    chk("ilv_main", 64'(MAIN_OUTSTANDING), 64'd2);
    chk("ilv_sgtx", 64'(SG_TX_OUTSTANDING), 64'd0);
    step(0, 0, 0, 2'd0, 2);
    chk("ilv_main0", 64'(MAIN_OUTSTANDING), 64'd0);
    chk("ilv_err0", 64'(ERR), 64'd0);

    // Underflow on SG RX, then illegal completion tag
    step(1, 2'd1, 10'd1, 0, 0);
    step(0, 0, 0, 2'd1, 2);
    chk("unf_cnt", 64'(SG_RX_OUTSTANDING), 64'd0);
    chk("unf_err", 64'(ERR), 64'd1);
    step(0, 0, 0, 2'd3, 1);
    chk("bad_tag_en", 64'({MAIN_DATA_EN, SG_RX_DATA_EN, SG_TX_DATA_EN}), 64'd0);
    chk("bad_tag_err", 64'(ERR), 64'd1);
    step(0, 0, 0, 0, 0);
    chk("err_sticky", 64'(ERR), 64'd1);

    // Main at 100, reset mid-transfer
    step(1, 2'd0, 10'd100, 0, 0);
    chk("main100", 64'(MAIN_OUTSTANDING), 64'd100);
    RST = 1'b1;
    step(0, 0, 0, 2'd0, 2);
    RST = 1'b0;
    chk("mid_rst_cnt", 64'(MAIN_OUTSTANDING), 64'd0);
    chk("mid_rst_done", 64'(MAIN_DONE), 64'd0);
    chk("mid_rst_err", 64'(ERR), 64'd0);
    step(1, 2'd0, 10'd3, 0, 0);
    chk("post_rst_3", 64'(MAIN_OUTSTANDING), 64'd3);

    // Saturation: 3 + 16*1024 exceeds 16383
    for (int k = 0; k < 16; k++) step(1, 2'd0, 10'd0, 0, 0);
    chk("sat_cnt", 64'(MAIN_OUTSTANDING), 64'(MAX));
    chk("sat_err", 64'(ERR), 64'd1);

    RST = 1'b1;
    step(0, 0, 0, 0, 0);
    RST = 1'b0;

    // Randomized traffic, with occasional big requests, illegal tags and resets
    for (int k = 0; k < 4000; k++) begin
      bit            iss;
      logic [1:0]    rt, ct;
      logic [9:0]    rl;
      logic [EW-1:0] en;
      iss = ($urandom_range(0, 7) == 0);
      rt  = ($urandom_range(0, 63) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rl  = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(1, 16));
      ct  = ($urandom_range(0, 63) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      en  = EW'($urandom_range(0, 2));
      RST = ($urandom_range(0, 499) == 0);
      step(iss, rt, rl, ct, en);
    end
    RST = 1'b0;
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
